// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding, quadrant codes and drain timing for the DDS ROM sequencer.
package dds_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam int ROM_LAT_DEF = 1;
  localparam int DRAIN_CYC = ROM_LAT_DEF + 1;
endpackage

// File: rtl/dds_valid_delay.sv
// dds_valid_delay: DEPTH-stage shift register carrying {valid, neg} alongside the ROM read.
module dds_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] din,
  output logic [1:0] dout
);
  logic [1:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/dds_rom_seq.sv
// dds_rom_seq: quarter-wave DDS sequencer driving a registered sine-magnitude ROM.
module dds_rom_seq
  import dds_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = DRAIN_CYC - 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fword,
  input  logic [PHASE_W-1:0] cfg_poff,
  input  logic [CNT_W-1:0]   cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W:0]    dout,
  output logic               dout_valid,
  output logic               done
);
  localparam int LO = PHASE_W - ADDR_W - 2;
  localparam int DRAIN_N = ROM_LAT + 1;
  localparam int DW = $clog2(DRAIN_N + 1);
  state_t state, state_n;
  logic [PHASE_W-1:0] fword, poff, acc;
  logic [CNT_W-1:0] burst, count;
  logic [DW-1:0] dcnt;
  logic [LO-1:0] lo_sum;
  logic carry;
  logic [ADDR_W+1:0] ph;
  logic [1:0] q;
  logic [ADDR_W-1:0] idx;
  logic issue, last, drain_end, mirror, neg;
  logic iss_v, iss_neg, dly_v, dly_neg;
  // only the top ADDR_W+2 phase bits matter; the low half just feeds its carry
  assign lo_sum = acc[LO-1:0] + poff[LO-1:0];
  assign carry = lo_sum < acc[LO-1:0];
  assign ph = acc[PHASE_W-1 -: ADDR_W+2] + poff[PHASE_W-1 -: ADDR_W+2] + (ADDR_W+2)'(carry);
  assign q = ph[ADDR_W+1:ADDR_W];
  assign idx = ph[ADDR_W-1:0];
  assign mirror = !(q inside {Q0, Q2});
  assign neg = q inside {Q2, Q3};
  assign cfg_ready = state == IDLE;
  assign busy = !cfg_ready;
  always_comb begin
    issue = state == RUN && !stop;
    last = issue && burst != '0 && count + CNT_W'(1) == burst;
    drain_end = state == DRAIN && dcnt == DW'(DRAIN_N - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? ((stop || last) ? DRAIN : RUN)
            : drain_end     ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      fword <= '0;
      poff <= '0;
      burst <= '0;
      acc <= '0;
      count <= '0;
      dcnt <= '0;
      rom_addr <= '0;
      iss_v <= 1'b0;
      iss_neg <= 1'b0;
      dout <= '0;
      dout_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        fword <= cfg_fword;
        poff <= cfg_poff;
        burst <= cfg_burst;
      end
      if (state == IDLE && start) begin
        acc <= '0;
        count <= '0;
      end
      if (issue) begin
        rom_addr <= mirror ? ~idx : idx;
        acc <= acc + fword;
        count <= count + CNT_W'(1);
      end
      dcnt <= state == DRAIN ? dcnt + DW'(1) : '0;
      done <= drain_end;
      iss_v <= issue;
      iss_neg <= neg;
      dout_valid <= dly_v;
      if (dly_v) dout <= dly_neg ? -{1'b0, rom_data} : {1'b0, rom_data};
    end
  end
  dds_valid_delay #(.DEPTH(ROM_LAT)) u_dly (
    .clk (clk),
    .rst (rst),
    .din ({iss_v, iss_neg}),
    .dout({dly_v, dly_neg})
  );
endmodule

// File: tb/tb_dds_rom_seq.sv
// tb_dds_rom_seq: directed runs checked every cycle against a phase-arithmetic model of the sine sequencer.
module tb_dds_rom_seq;
  logic clk, rst, cfg_valid, cfg_ready, start, stop, busy, dout_valid, done;
  logic [31:0] cfg_fword, cfg_poff;
  logic [15:0] cfg_burst, rom_data;
  logic [7:0] rom_addr;
  logic [16:0] dout;
  int checks = 0, failures = 0, cyc = 0, rd = 0, run_e0 = 0, first_s0 = 0;
  int exp_q[$];
  int v_edges[$];
  int d_edges[$];
  int dout_hist[int];
  int addr_hist[int];
  dds_rom_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_poff(cfg_poff), .cfg_burst(cfg_burst),
    .start(start), .stop(stop), .busy(busy), .rom_addr(rom_addr),
    .rom_data(rom_data), .dout(dout), .dout_valid(dout_valid), .done(done)
  );
  function automatic logic [15:0] rom_f(input logic [7:0] a);
    return {a, a} ^ 16'h5A5A;
  endfunction
  always_ff @(posedge clk) rom_data <= rom_f(rom_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  // sample k sits at phase poff + k*fword; the quadrant picks mirror and sign
  function automatic int model(input logic [31:0] fw, input logic [31:0] po, input int k);
    logic [31:0] ph;
    logic [7:0] a;
    int mag;
    ph = po + fw * 32'(k);
    a = ph[30] ? ~ph[29:22] : ph[29:22];
    mag = int'(rom_f(a));
    return ph[31] ? -mag : mag;
  endfunction
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    cyc++;
    dout_hist[cyc] = $signed(dout);
    addr_hist[cyc] = int'(rom_addr);
    if (dout_valid) begin
      v_edges.push_back(cyc);
      if (rd < exp_q.size()) begin
        chk($sformatf("dout[%0d]", rd), $signed(dout), exp_q[rd]);
        rd++;
      end else chk("extra_valid", 1, 0);
    end
    if (done) d_edges.push_back(cyc);
  endtask
  task automatic run(input logic [31:0] fw, input logic [31:0] po, input logic [15:0] bu,
                     input int stop_at, input bit disturb);
    int n, vs, ds, e0;
    bit burst_end;
    n = stop_at == 0 ? int'(bu) : bu == 0 ? stop_at - 1 : (int'(bu) < stop_at - 1 ? int'(bu) : stop_at - 1);
    burst_end = bu != 0 && (stop_at == 0 || int'(bu) < stop_at);
    for (int k = 0; k < n; k++) exp_q.push_back(model(fw, po, k));
    vs = v_edges.size();
    ds = d_edges.size();
    cfg_valid = 1'b1; cfg_fword = fw; cfg_poff = po; cfg_burst = bu; start = 1'b1;
    e0 = cyc + 1;
    run_e0 = e0;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int t = 1; t < 3000 && d_edges.size() == ds; t++) begin
      stop = t == stop_at;
      start = disturb && t == 4;
      cfg_valid = disturb && t == 4;
      if (disturb && t == 4) begin
        cfg_fword = ~fw; cfg_burst = 16'd1;
        chk("cfg_ready_in_run", int'(cfg_ready), 0);
        chk("busy_in_run", int'(busy), 1);
      end
      tick();
    end
    stop = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    if (d_edges.size() == ds) chk("done_timeout", 0, 1);
    else begin
      chk("n_valid", v_edges.size() - vs, n);
      if (n > 0) begin
        chk("first_valid_lat", v_edges[vs] - e0, 3);
        chk("last_valid_lat", v_edges[v_edges.size()-1] - e0, n + 2);
      end
      chk("done_lat", d_edges[ds] - e0, burst_end ? int'(bu) + 2 : stop_at + 2);
      chk("model_consumed", rd, exp_q.size());
      tick();
      chk("cfg_ready_after_done", int'(cfg_ready), 1);
      repeat (3) tick();
      chk("done_pulses", d_edges.size() - ds, 1);
    end
  endtask
  initial begin
    int vs, ds;
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_fword = '0; cfg_poff = '0; cfg_burst = '0;
    repeat (2) tick();
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    tick();
    chk("pin_model_s256", model(32'h0040_0000, 0, 256), 42405);
    chk("pin_model_wrap1", model(32'hFFC0_0000, 0, 1), -23130);
    ds = d_edges.size();
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (3) tick();
    chk("idle_stop_busy", int'(busy), 0);
    chk("idle_stop_done", d_edges.size() - ds, 0);
    run(32'h0040_0000, 32'h0, 16'd1024, 0, 1'b0);
    chk("q0_addr_first", addr_hist[run_e0 + 1], 0);
    chk("q0_addr_last", addr_hist[run_e0 + 1 + 255], 255);
    chk("q1_addr_first", addr_hist[run_e0 + 1 + 256], 255);
    chk("q1_addr_last", addr_hist[run_e0 + 1 + 511], 0);
    chk("q2_addr_first", addr_hist[run_e0 + 1 + 512], 0);
    chk("q3_addr_first", addr_hist[run_e0 + 1 + 768], 255);
    chk("q3_addr_last", addr_hist[run_e0 + 1 + 1023], 0);
    chk("q0_dout_s0", dout_hist[run_e0 + 3], 23130);
    chk("q2_dout_s512", dout_hist[run_e0 + 3 + 512], -23130);
    run(32'h0, 32'h4000_0000, 16'd4, 0, 1'b0);
    for (int k = 0; k < 4; k++) chk("poff_addr", addr_hist[run_e0 + 1 + k], 255);
    chk("poff_dout", dout_hist[run_e0 + 6], 42405);
    run(32'h0100_0000, 32'h0, 16'd0, 10, 1'b0);
    run(32'h0100_0000, 32'h0, 16'd8, 1, 1'b0);
    run(32'h0080_0000, 32'h1000_0000, 16'd20, 0, 1'b1);
    run(32'h0200_0000, 32'h0, 16'd5, 5, 1'b0);
    cfg_valid = 1'b1; cfg_fword = 32'h0100_0000; cfg_poff = 32'h1234_5678; cfg_burst = 16'd100;
    start = 1'b1;
    run_e0 = cyc + 1;
    for (int k = 0; k < 100; k++) exp_q.push_back(model(32'h0100_0000, 32'h1234_5678, k));
    vs = v_edges.size();
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int t = 0; t < 50 && v_edges.size() - vs < 5; t++) tick();
    chk("pre_rst_valids", v_edges.size() - vs, 5);
    first_s0 = dout_hist[run_e0 + 3];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd = exp_q.size();
    chk("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_rom_addr", int'(rom_addr), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cfg_ready", int'(cfg_ready), 1);
    chk("midrst_done", int'(done), 0);
    vs = v_edges.size();
    ds = d_edges.size();
    repeat (6) tick();
    chk("midrst_no_done", d_edges.size() - ds, 0);
    chk("midrst_no_valid", v_edges.size() - vs, 0);
    run(32'h0100_0000, 32'h1234_5678, 16'd3, 0, 1'b0);
    chk("rerun_s0_same", dout_hist[run_e0 + 3], first_s0);
    chk("rerun_s0_pin", dout_hist[run_e0 + 3], 4626);
    run(32'hFFC0_0000, 32'h0, 16'd3, 0, 1'b0);
    chk("wrap_addr0", addr_hist[run_e0 + 1], 0);
    chk("wrap_addr1", addr_hist[run_e0 + 2], 0);
    chk("wrap_addr2", addr_hist[run_e0 + 3], 1);
    chk("wrap_dout0", dout_hist[run_e0 + 3], 23130);
    chk("wrap_dout1", dout_hist[run_e0 + 4], -23130);
    chk("wrap_dout2", dout_hist[run_e0 + 5], -23387);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
